// File: rtl/cla4_seq_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cla4_seq_adder_ctrl_pkg
//   Shared definitions for the nibble-serial add/subtract unit:
//   - state_t  : controller FSM encoding (IDLE, RUN, DONE)
//   - NIBBLE_W : width of one slice handled by the cla4 cell per cycle
// -----------------------------------------------------------------------------
package cla4_seq_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : cla4_seq_adder_ctrl_pkg

// File: rtl/cla4_seq_adder_ctrl_cla4.sv
// -----------------------------------------------------------------------------
// cla4
//   Purely combinational 4-bit carry-lookahead adder cell.
//   Ports:
//     din1, din2 [3:0] : addends
//     carry_in         : carry into bit 0
//     dout [3:0]       : sum
//     carry_out        : carry out of bit 3
//     overflow         : signed overflow of this slice (c3 ^ c4)
// -----------------------------------------------------------------------------
module cla4
  import cla4_seq_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] din1,
  input  logic [NIBBLE_W-1:0] din2,
  input  logic                carry_in,
  output logic [NIBBLE_W-1:0] dout,
  output logic                carry_out,
  output logic                overflow
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = din1 & din2;
  assign p = din1 ^ din2;

  // Every carry is a flat sum-of-products of generate/propagate terms, so no
  // carry waits on the one below it.
  assign c[0] = carry_in;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign dout      = p ^ c[NIBBLE_W-1:0];
  assign carry_out = c[4];
  assign overflow  = c[3] ^ c[4];

endmodule : cla4

// File: rtl/cla4_seq_adder_ctrl.sv
// -----------------------------------------------------------------------------
// cla4_seq_adder_ctrl
//   Multi-cycle WIDTH-bit add/subtract built around a single cla4 cell that
//   processes one nibble per cycle, least-significant nibble first.
//   Subtraction is a + ~b + 1: b is inverted at acceptance and the carry
//   register is seeded with 1.
//   WIDTH must be a multiple of 4 and at least 8.
//   Ports:
//     clk, rst        : clock (rising edge), synchronous active-high reset
//     start           : request, accepted only in IDLE
//     sub             : 0 = a+b, 1 = a-b (sampled with start)
//     a, b [WIDTH]    : operands (sampled with start)
//     busy            : high from the cycle after acceptance through done
//     done            : one-cycle pulse; result/flags valid from here on
//     result [WIDTH]  : sum/difference, holds until the next accepted start
//     carry_out       : carry out of MSB (for sub: 1 = no borrow)
//     overflow        : signed overflow of the full-width operation
// -----------------------------------------------------------------------------
module cla4_seq_adder_ctrl
  import cla4_seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NIB    = WIDTH / NIBBLE_W;
  localparam int IDX_W  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int BASE_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t             state;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [BASE_W-1:0]   base;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic                nib_ovf;

  // Nibble select: bit offset of the slice being worked on this cycle.
  assign base  = BASE_W'(idx) * BASE_W'(NIBBLE_W);
  assign nib_a = op_a[base +: NIBBLE_W];
  assign nib_b = op_b[base +: NIBBLE_W];

  cla4 u_cla4 (
    .din1      (nib_a),
    .din2      (nib_b),
    .carry_in  (carry),
    .dout      (nib_sum),
    .carry_out (nib_cout),
    .overflow  (nib_ovf)
  );

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; blocking = would make ordering matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a   <= a;
            op_b   <= sub ? ~b : b;
            carry  <= sub;
            idx    <= '0;
            result <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          result[base +: NIBBLE_W] <= nib_sum;
          carry                    <= nib_cout;
          if (idx == LAST_IDX) begin
            // Top nibble: its carry/overflow are the full-width flags.
            carry_out <= nib_cout;
            overflow  <= nib_ovf;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : cla4_seq_adder_ctrl

// File: tb/tb_cla4_seq_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cla4_seq_adder_ctrl
//   Self-checking bench for cla4_seq_adder_ctrl (WIDTH=32). Inputs are driven
//   and outputs sampled on the falling edge. Expected values come from a
//   plain-arithmetic model of add/subtract with unsigned carry/borrow and
//   signed-range overflow.
// -----------------------------------------------------------------------------
module tb_cla4_seq_adder_ctrl;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;
  localparam int LAT   = NIB + 1;   // falling edges from start-driven to done

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cla4_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic, carry = unsigned carry / no-borrow,
  // overflow = true signed result outside the 32-bit signed range.
  function automatic void model(input logic [31:0] ta, input logic [31:0] tb,
                                input logic ts, output logic [31:0] r,
                                output logic co, output logic ov);
    longint      sa, sb, sr;
    logic [32:0] u;
    sa = $signed(ta);
    sb = $signed(tb);
    if (ts) begin
      u  = {1'b0, ta} - {1'b0, tb};
      co = (ta >= tb);
      sr = sa - sb;
    end else begin
      u  = {1'b0, ta} + {1'b0, tb};
      co = u[32];
      sr = sa + sb;
    end
    r  = u[31:0];
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  // One complete operation: single-cycle start pulse, then wait for done.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                        input logic ts, input string tag);
    logic [31:0] er;
    logic        ec, eo, busy_ok;
    int          lat;
    model(ta, tb, ts, er, ec, eo);
    @(negedge clk);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    busy_ok = 1'b1;
    lat     = 1;
    while (done !== 1'b1 && lat < 4 * LAT) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_busy_span"}, 64'(busy_ok), 64'd1);
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_carry"}, 64'(carry_out), 64'(ec));
    check({tag, "_ovf"}, 64'(overflow), 64'(eo));
    @(negedge clk);
    check({tag, "_done_1cyc"}, 64'(done), 64'd0);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_hold"}, 64'(result), 64'(er));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] er, ra, rb;
    logic        ec, eo, rs;
    int          pulses, first_at, last_at, gap_ok, gap;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({carry_out, overflow}), 64'd0);
    rst = 1'b0;

    // Directed cases
    run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, "t1_wrap");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "t2_posovf");
    run_op(32'd5,         32'd7,         1'b1, "t3_borrow");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, "t3_negovf");

    // Start during RUN is ignored
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; first_at = -1;
    for (int i = 4; i <= 3 * LAT; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        if (first_at < 0) begin
          first_at = i;
          check("t4_result", 64'(result), 64'h2345_6789);
        end
      end
    end
    check("t4_pulses", 64'(pulses), 64'd1);
    check("t4_latency", 64'(first_at), 64'(LAT));

    // Leave flags set so reset clearing them is observable
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, "t5_pre");

    // Reset mid-RUN
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_result", 64'(result), 64'd0);
    check("t5_flags", 64'({carry_out, overflow}), 64'd0);
    pulses = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("t5_no_done", 64'(pulses), 64'd0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "t5_fresh");

    // start held high for 30 cycles
    @(negedge clk);
    a = 32'h0000_000F; b = 32'h0000_000F; sub = 1'b0; start = 1'b1;
    pulses = 0; first_at = -1; last_at = -1; gap_ok = 1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 30) start = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i;
        else begin
          gap = i - last_at;
          if (gap != NIB + 2) gap_ok = 0;
        end
        last_at = i;
        check("t6_result", 64'({result, carry_out, overflow}), 64'({32'h0000_001E, 2'b00}));
      end
    end
    check("t6_pulses", 64'(pulses), 64'd3);
    check("t6_first", 64'(first_at), 64'(LAT));
    check("t6_spacing", 64'(gap_ok), 64'd1);

    // Randomized operations, with idle gaps checking result hold
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'h7FFF_FFFF;
        1:       rb = 32'h0000_0000;
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, $sformatf("rnd%0d", n));
      model(ra, rb, rs, er, ec, eo);
      a = $urandom; b = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check($sformatf("rnd%0d_idle", n), 64'({result, carry_out, overflow, busy}),
            64'({er, ec, eo, 1'b0}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cla4_seq_adder_ctrl
